// File: rtl/axonerve_kvs_model_if.sv
// Command/response bundle of the Axonerve KVS model.
// master = host command generator, slave = KVS responder.
interface axonerve_kvs_model_if;
  logic [31:0]  O_VERSION;
  logic         O_READY;
  logic         O_WAIT;
  logic         O_ACK;
  logic         O_ENT_ERR;
  logic         O_SINGLE_HIT;
  logic         O_MULTIL_HIT;
  logic [127:0] O_KEY_DAT;
  logic [127:0] O_EKEY_MSK;
  logic [6:0]   O_KEY_PRI;
  logic [31:0]  O_KEY_VALUE;
  logic         O_CMD_EMPTY;
  logic         O_CMD_FULL;
  logic         O_ENT_FULL;
  logic         I_CMD_INIT;
  logic         I_CMD_VALID;
  logic         I_CMD_ERASE;
  logic         I_CMD_WRITE;
  logic         I_CMD_READ;
  logic         I_CMD_SEARCH;
  logic         I_CMD_UPDATE;
  logic [127:0] I_KEY_DAT;
  logic [127:0] I_EKEY_MSK;
  logic [6:0]   I_KEY_PRI;
  logic [31:0]  I_KEY_VALUE;

  modport master (
    output I_CMD_INIT, I_CMD_VALID,
    output I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ,
    output I_CMD_SEARCH, I_CMD_UPDATE,
    output I_KEY_DAT, I_EKEY_MSK, I_KEY_PRI, I_KEY_VALUE,
    input  O_VERSION, O_READY, O_WAIT, O_ACK,
    input  O_ENT_ERR, O_SINGLE_HIT, O_MULTIL_HIT,
    input  O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE,
    input  O_CMD_EMPTY, O_CMD_FULL, O_ENT_FULL
  );

  modport slave (
    input  I_CMD_INIT, I_CMD_VALID,
    input  I_CMD_ERASE, I_CMD_WRITE, I_CMD_READ,
    input  I_CMD_SEARCH, I_CMD_UPDATE,
    input  I_KEY_DAT, I_EKEY_MSK, I_KEY_PRI, I_KEY_VALUE,
    output O_VERSION, O_READY, O_WAIT, O_ACK,
    output O_ENT_ERR, O_SINGLE_HIT, O_MULTIL_HIT,
    output O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE,
    output O_CMD_EMPTY, O_CMD_FULL, O_ENT_FULL
  );
endinterface

// File: rtl/axonerve_kvs_model.sv
// Behavioural Axonerve KVS responder: command FIFO, ternary table, scan engine.
// Ports: I_CLK, I_XRST (sync, active-low), kvs (slave bundle);
// AXONERVE_KVS_MODEL_STATS_EN adds O_SEARCH_HITS / O_SEARCH_MISSES.
module axonerve_kvs_model #(
  parameter int          DEPTH      = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input logic I_CLK,
  input logic I_XRST,
  axonerve_kvs_model_if.slave kvs
`ifdef AXONERVE_KVS_MODEL_STATS_EN
  ,
  output logic [31:0] O_SEARCH_HITS,
  output logic [31:0] O_SEARCH_MISSES
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  // op = {erase, write, read, search, update}
  typedef struct packed {
    logic [4:0]   op;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
  } cmd_t;

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_SCAN, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q;

  cmd_t fifo_q [FIFO_DEPTH];
  logic [FW:0] wp_q, rp_q;
  logic empty, full, push, pop;
  cmd_t cmd_q;

  logic [DEPTH-1:0] vld_q;
  logic [127:0] key_q [DEPTH];
  logic [127:0] msk_q [DEPTH];
  logic [6:0]   pri_q [DEPTH];
  logic [31:0]  val_q [DEPTH];

  logic          ex_hit_q, fr_hit_q;
  logic [IW-1:0] ex_idx_q, fr_idx_q, win_idx_q;
  logic [6:0]    win_pri_q;
  logic [1:0]    mcnt_q;

  logic         ack_q, err_q, sh_q, mh_q, ent_full_q;
  logic [127:0] res_key_q, res_msk_q;
  logic [6:0]   res_pri_q;
  logic [31:0]  res_val_q;

  logic         r_err, r_sh, r_mh, t_wr, t_inv, t_upd, is_srch;
  logic [127:0] r_key, r_msk;
  logic [6:0]   r_pri;
  logic [31:0]  r_val;
  logic         cur_ex, cur_tn;
  logic [IW-1:0] rd_idx;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FW] != rp_q[FW]) &&
                 (wp_q[FW-1:0] == rp_q[FW-1:0]);
  assign push  = kvs.I_CMD_VALID && (state_q != S_INIT) && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign kvs.O_VERSION    = VERSION;
  assign kvs.O_READY      = (state_q != S_INIT);
  assign kvs.O_WAIT       = (state_q == S_INIT) || full;
  assign kvs.O_ACK        = ack_q;
  assign kvs.O_ENT_ERR    = err_q;
  assign kvs.O_SINGLE_HIT = sh_q;
  assign kvs.O_MULTIL_HIT = mh_q;
  assign kvs.O_KEY_DAT    = res_key_q;
  assign kvs.O_EKEY_MSK   = res_msk_q;
  assign kvs.O_KEY_PRI    = res_pri_q;
  assign kvs.O_KEY_VALUE  = res_val_q;
  assign kvs.O_CMD_EMPTY  = empty;
  assign kvs.O_CMD_FULL   = full;
  assign kvs.O_ENT_FULL   = ent_full_q;

  // per-entry compare for the entry currently being scanned
  assign cur_ex = vld_q[idx_q] && (key_q[idx_q] == cmd_q.key) &&
                  (msk_q[idx_q] == cmd_q.msk);
  assign cur_tn = vld_q[idx_q] &&
                  (((key_q[idx_q] ^ cmd_q.key) & ~msk_q[idx_q]) == '0);
  assign rd_idx = cmd_q.val[IW-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: if (idx_q == IW'(DEPTH - 1)) state_d = S_IDLE;
      S_IDLE: begin
        if (!empty) state_d = S_SCAN;
        else if (kvs.I_CMD_INIT) state_d = S_INIT;
      end
      S_SCAN: if (idx_q == IW'(DEPTH - 1)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // response and table-update decision, used only in S_RESP
  always_comb begin
    r_err = 1'b0; r_sh = 1'b0; r_mh = 1'b0;
    r_key = '0; r_msk = '0; r_pri = '0; r_val = '0;
    t_wr = 1'b0; t_inv = 1'b0; t_upd = 1'b0; is_srch = 1'b0;
    if (!$onehot(cmd_q.op)) begin
      r_err = 1'b1;
    end else begin
      unique case (1'b1)
        cmd_q.op[4]: if (ex_hit_q) t_inv = 1'b1; else r_err = 1'b1;
        cmd_q.op[3]: begin
          if (ex_hit_q || !fr_hit_q) r_err = 1'b1;
          else t_wr = 1'b1;
        end
        cmd_q.op[2]: begin
          r_sh  = vld_q[rd_idx];
          r_key = key_q[rd_idx];
          r_msk = msk_q[rd_idx];
          r_pri = pri_q[rd_idx];
          r_val = val_q[rd_idx];
        end
        cmd_q.op[1]: begin
          is_srch = 1'b1;
          if (mcnt_q != 2'd0) begin
            r_sh  = (mcnt_q == 2'd1);
            r_mh  = (mcnt_q == 2'd2);
            r_key = key_q[win_idx_q];
            r_msk = msk_q[win_idx_q];
            r_pri = pri_q[win_idx_q];
            r_val = val_q[win_idx_q];
          end
        end
        cmd_q.op[0]: if (ex_hit_q) t_upd = 1'b1; else r_err = 1'b1;
        default: r_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_XRST) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      vld_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      sh_q       <= 1'b0;
      mh_q       <= 1'b0;
      ent_full_q <= 1'b0;
      res_key_q  <= '0;
      res_msk_q  <= '0;
      res_pri_q  <= '0;
      res_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= 1'b0;
      ent_full_q <= &vld_q;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      unique case (state_q)
        S_INIT: begin
          vld_q[idx_q] <= 1'b0;
          idx_q <= idx_q + 1'b1;
        end
        S_IDLE: idx_q <= '0;
        S_SCAN: idx_q <= idx_q + 1'b1;
        S_RESP: begin
          ack_q     <= 1'b1;
          err_q     <= r_err;
          sh_q      <= r_sh;
          mh_q      <= r_mh;
          res_key_q <= r_key;
          res_msk_q <= r_msk;
          res_pri_q <= r_pri;
          res_val_q <= r_val;
          if (t_inv) vld_q[ex_idx_q] <= 1'b0;
          if (t_wr) vld_q[fr_idx_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // datapath storage and scan accumulators need no reset
  always_ff @(posedge I_CLK) begin
    if (push) fifo_q[wp_q[FW-1:0]] <= {kvs.I_CMD_ERASE, kvs.I_CMD_WRITE,
      kvs.I_CMD_READ, kvs.I_CMD_SEARCH, kvs.I_CMD_UPDATE, kvs.I_KEY_DAT,
      kvs.I_EKEY_MSK, kvs.I_KEY_PRI, kvs.I_KEY_VALUE};
    if (pop) begin
      cmd_q    <= fifo_q[rp_q[FW-1:0]];
      ex_hit_q <= 1'b0;
      fr_hit_q <= 1'b0;
      mcnt_q   <= 2'd0;
    end
    if (state_q == S_SCAN) begin
      if (cur_ex && !ex_hit_q) begin
        ex_hit_q <= 1'b1;
        ex_idx_q <= idx_q;
      end
      if (!vld_q[idx_q] && !fr_hit_q) begin
        fr_hit_q <= 1'b1;
        fr_idx_q <= idx_q;
      end
      // strict < keeps the lowest index on a priority tie
      if (cur_tn) begin
        if (mcnt_q == 2'd0 || pri_q[idx_q] < win_pri_q) begin
          win_idx_q <= idx_q;
          win_pri_q <= pri_q[idx_q];
        end
        if (mcnt_q != 2'd2) mcnt_q <= mcnt_q + 1'b1;
      end
    end
    if (state_q == S_RESP && t_wr) begin
      key_q[fr_idx_q] <= cmd_q.key;
      msk_q[fr_idx_q] <= cmd_q.msk;
      pri_q[fr_idx_q] <= cmd_q.pri;
      val_q[fr_idx_q] <= cmd_q.val;
    end
    if (state_q == S_RESP && t_upd) val_q[ex_idx_q] <= cmd_q.val;
  end

`ifdef AXONERVE_KVS_MODEL_STATS_EN
  logic [31:0] hits_q, miss_q;
  assign O_SEARCH_HITS   = hits_q;
  assign O_SEARCH_MISSES = miss_q;

  always_ff @(posedge I_CLK) begin
    if (!I_XRST || state_q == S_INIT) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (state_q == S_RESP && is_srch) begin
      if (mcnt_q != 2'd0) hits_q <= hits_q + 1'b1;
      else miss_q <= miss_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axonerve_kvs_model.sv
// Directed self-checking bench for axonerve_kvs_model.
// Vector tables plus hand sequences for fill, INIT, FIFO and reset.
module tb_axonerve_kvs_model;
  localparam int DEPTH = 8;
  localparam int LAT = DEPTH + 2;
  localparam logic [4:0] OP_E = 5'b10000;
  localparam logic [4:0] OP_W = 5'b01000;
  localparam logic [4:0] OP_R = 5'b00100;
  localparam logic [4:0] OP_S = 5'b00010;
  localparam logic [4:0] OP_U = 5'b00001;
  localparam logic [127:0] K1 = {4{32'habadcafe}};
  localparam logic [127:0] K2 = {4{32'hdeadbeef}};
  localparam logic [127:0] B  = {4{32'h12345600}};

  typedef struct {
    logic [4:0]   op;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
    logic         err;
    logic         sh;
    logic         mh;
    logic [31:0]  rval;
    logic [6:0]   rpri;
  } vec_t;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axonerve_kvs_model_if kif ();
`ifdef AXONERVE_KVS_MODEL_STATS_EN
  logic [31:0] s_hits, s_miss;
`endif

  axonerve_kvs_model #(.DEPTH(DEPTH)) dut (
    .I_CLK (clk),
    .I_XRST(xrst),
    .kvs   (kif)
`ifdef AXONERVE_KVS_MODEL_STATS_EN
    ,
    .O_SEARCH_HITS  (s_hits),
    .O_SEARCH_MISSES(s_miss)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, a, e);
  endtask

  task automatic issue(input logic [4:0] op, input logic [127:0] k,
                       input logic [127:0] m, input logic [6:0] p,
                       input logic [31:0] v, output int lat);
    @(negedge clk);
    {kif.I_CMD_ERASE, kif.I_CMD_WRITE, kif.I_CMD_READ,
     kif.I_CMD_SEARCH, kif.I_CMD_UPDATE} = op;
    kif.I_KEY_DAT = k;
    kif.I_EKEY_MSK = m;
    kif.I_KEY_PRI = p;
    kif.I_KEY_VALUE = v;
    kif.I_CMD_VALID = 1'b1;
    @(posedge clk);
    #1;
    kif.I_CMD_VALID = 1'b0;
    lat = 0;
    while (!kif.O_ACK && lat < 4 * LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    issue(v.op, v.key, v.msk, v.pri, v.val, lat);
    chk({nm, ".lat"}, 128'(lat), 128'(LAT));
    chk({nm, ".err"}, 128'(kif.O_ENT_ERR), 128'(v.err));
    chk({nm, ".sh"}, 128'(kif.O_SINGLE_HIT), 128'(v.sh));
    chk({nm, ".mh"}, 128'(kif.O_MULTIL_HIT), 128'(v.mh));
    chk({nm, ".val"}, 128'(kif.O_KEY_VALUE), 128'(v.rval));
    chk({nm, ".pri"}, 128'(kif.O_KEY_PRI), 128'(v.rpri));
  endtask

  task automatic wait_ready(input string nm);
    int c = 0;
    while (!kif.O_READY && c < 4 * DEPTH) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(nm, 128'(kif.O_READY), 128'(1));
  endtask

  initial begin
    vec_t va[13];
    vec_t vb[7];
    int lat;
    int nack;

    kif.I_CMD_INIT = 1'b0;
    kif.I_CMD_VALID = 1'b0;
    {kif.I_CMD_ERASE, kif.I_CMD_WRITE, kif.I_CMD_READ,
     kif.I_CMD_SEARCH, kif.I_CMD_UPDATE} = 5'b0;
    kif.I_KEY_DAT = '0;
    kif.I_EKEY_MSK = '0;
    kif.I_KEY_PRI = '0;
    kif.I_KEY_VALUE = '0;

    va[0]  = '{OP_W, K1, 0, 7'd0, 32'h34343434, 0, 0, 0, 0, 0};
    va[1]  = '{OP_S, K1, 0, 7'd0, 0, 0, 1, 0, 32'h34343434, 0};
    va[2]  = '{OP_W, K2, 0, 7'd3, 32'ha5a5a5a5, 0, 0, 0, 0, 0};
    va[3]  = '{OP_U, K1, 0, 7'd0, 32'hfefefefe, 0, 0, 0, 0, 0};
    va[4]  = '{OP_S, K1, 0, 7'd0, 0, 0, 1, 0, 32'hfefefefe, 0};
    va[5]  = '{OP_S, K2, 0, 7'd0, 0, 0, 1, 0, 32'ha5a5a5a5, 3};
    va[6]  = '{OP_E, K1, 0, 7'd0, 0, 0, 0, 0, 0, 0};
    va[7]  = '{OP_S, K1, 0, 7'd0, 0, 0, 0, 0, 0, 0};
    va[8]  = '{OP_E, K1, 0, 7'd0, 0, 1, 0, 0, 0, 0};
    va[9]  = '{OP_R, 0, 0, 7'd0, 32'd1, 0, 1, 0, 32'ha5a5a5a5, 3};
    va[10] = '{OP_R, 0, 0, 7'd0, 32'd0, 0, 0, 0, 32'hfefefefe, 0};
    va[11] = '{OP_W | OP_R, K1, 0, 7'd0, 0, 1, 0, 0, 0, 0};
    va[12] = '{OP_U, K1, 0, 7'd0, 32'h1, 1, 0, 0, 0, 0};

    vb[0] = '{OP_W, B, 128'hFF, 7'd5, 32'h1111, 0, 0, 0, 0, 0};
    vb[1] = '{OP_W, B, 128'hFFFF, 7'd2, 32'h2222, 0, 0, 0, 0, 0};
    vb[2] = '{OP_S, B | 128'h0F, 0, 7'd0, 0, 0, 0, 1, 32'h2222, 2};
    vb[3] = '{OP_S, B ^ 128'h0F00, 0, 7'd0, 0, 0, 1, 0, 32'h2222, 2};
    vb[4] = '{OP_W, B ^ 128'h0F0000, 128'hFFFFFF, 7'd2, 32'h3333,
              0, 0, 0, 0, 0};
    vb[5] = '{OP_S, B ^ 128'h0F00, 0, 7'd0, 0, 0, 0, 1, 32'h2222, 2};
    vb[6] = '{OP_S, B ^ 128'h0F0000, 0, 7'd0, 0, 0, 1, 0, 32'h3333, 2};

    repeat (10) @(posedge clk);
    #1;
    chk("rst.ready", 128'(kif.O_READY), 128'(0));
    chk("rst.ack", 128'(kif.O_ACK), 128'(0));
    chk("rst.empty", 128'(kif.O_CMD_EMPTY), 128'(1));
    chk("rst.full", 128'(kif.O_CMD_FULL), 128'(0));
    chk("rst.entfull", 128'(kif.O_ENT_FULL), 128'(0));
    chk("rst.ver", 128'(kif.O_VERSION), 128'(32'h0001_0000));
    chk("rst.val", 128'(kif.O_KEY_VALUE), 128'(0));
    @(negedge clk);
    xrst = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      if (k == DEPTH - 1) chk("init.notyet", 128'(kif.O_READY), 128'(0));
      if (k == DEPTH) chk("init.ready", 128'(kif.O_READY), 128'(1));
    end

    for (int i = 0; i < 13; i++) run_vec($sformatf("va%0d", i), va[i]);

    // entry 0 free, entry 1 holds K2: seven more writes fill the table
    for (int i = 0; i < 7; i++) begin
      issue(OP_W, {4{32'(32'h1000_0000 + i)}}, 0, 7'd1, 32'(i), lat);
      chk($sformatf("fill%0d.err", i), 128'(kif.O_ENT_ERR), 128'(0));
      if (i == 5) chk("fill.notfull", 128'(kif.O_ENT_FULL), 128'(0));
    end
    @(posedge clk);
    #1;
    chk("fill.entfull", 128'(kif.O_ENT_FULL), 128'(1));
    issue(OP_W, {4{32'h7777_7777}}, 0, 7'd1, 32'h9, lat);
    chk("ninth.err", 128'(kif.O_ENT_ERR), 128'(1));
    issue(OP_W, K2, 0, 7'd3, 32'h9, lat);
    chk("dup.err", 128'(kif.O_ENT_ERR), 128'(1));

    @(negedge clk);
    kif.I_CMD_INIT = 1'b1;
    @(posedge clk);
    #1;
    kif.I_CMD_INIT = 1'b0;
    chk("cmdinit.busy", 128'(kif.O_READY), 128'(0));
    wait_ready("cmdinit.ready");
    @(posedge clk);
    #1;
    chk("cmdinit.entfull", 128'(kif.O_ENT_FULL), 128'(0));

    for (int i = 0; i < 7; i++) run_vec($sformatf("vb%0d", i), vb[i]);
    issue(OP_S, 128'h0, 0, 7'd0, 0, lat);
    chk("nohit.sh", 128'(kif.O_SINGLE_HIT | kif.O_MULTIL_HIT), 128'(0));
    chk("nohit.key", kif.O_KEY_DAT, 128'(0));

    // hold VALID for six edges: five accepted, one dropped at full
    nack = 0;
    @(negedge clk);
    {kif.I_CMD_ERASE, kif.I_CMD_WRITE, kif.I_CMD_READ,
     kif.I_CMD_SEARCH, kif.I_CMD_UPDATE} = OP_S;
    kif.I_KEY_DAT = B;
    kif.I_CMD_VALID = 1'b1;
    for (int c = 1; c <= 8 * LAT; c++) begin
      @(posedge clk);
      #1;
      if (kif.O_ACK) nack++;
      if (c == 4) chk("hold.notfull", 128'(kif.O_CMD_FULL), 128'(0));
      if (c == 5) begin
        chk("hold.full", 128'(kif.O_CMD_FULL), 128'(1));
        chk("hold.wait", 128'(kif.O_WAIT), 128'(1));
      end
      if (c == 6) kif.I_CMD_VALID = 1'b0;
    end
    chk("hold.acks", 128'(nack), 128'(5));
    chk("hold.empty", 128'(kif.O_CMD_EMPTY), 128'(1));

    // reset while the scan is in progress must swallow the ACK
    @(negedge clk);
    kif.I_CMD_VALID = 1'b1;
    @(posedge clk);
    #1;
    kif.I_CMD_VALID = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    xrst = 1'b0;
    nack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    xrst = 1'b1;
    for (int c = 0; c < 3 * LAT; c++) begin
      @(posedge clk);
      #1;
      if (kif.O_ACK) nack++;
    end
    chk("midreset.noack", 128'(nack), 128'(0));
    chk("midreset.empty", 128'(kif.O_CMD_EMPTY), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
